// File: rtl/gate_bist_checker_pkg.sv
// Shared definitions for the gate block self-test checker: FSM encoding,
// gate bit positions within the packed gate output bus.
package gate_bist_checker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam int GATE_N = 7;

   localparam int AND_B  = 0;
   localparam int NAND_B = 1;
   localparam int OR_B   = 2;
   localparam int NOR_B  = 3;
   localparam int NOT_B  = 4;
   localparam int XOR_B  = 5;
   localparam int XNOR_B = 6;

endpackage

// File: rtl/gate_bist_checker_gate_expect.sv
// Golden truth table of the primitive gate block: input vector ab -> the seven
// expected gate outputs, packed with the same bit positions as the gate bus.
module gate_expect
   import gate_bist_checker_pkg::*;
(
   input  logic [1:0]        i_ab,
   output logic [GATE_N-1:0] o_expected
);

   logic w_a;
   logic w_b;

   assign w_a = i_ab[1];
   assign w_b = i_ab[0];

   always_comb begin
      o_expected         = '0;
      o_expected[AND_B]  = w_a & w_b;
      o_expected[NAND_B] = ~(w_a & w_b);
      o_expected[OR_B]   = w_a | w_b;
      o_expected[NOR_B]  = ~(w_a | w_b);
      o_expected[NOT_B]  = ~w_a;
      o_expected[XOR_B]  = w_a ^ w_b;
      o_expected[XNOR_B] = ~(w_a ^ w_b);
   end

endmodule

// File: rtl/gate_bist_checker.sv
// Built-in self-test sequencer/checker for the two-input gate block.
// Optional first-failure capture ports are enabled with GATE_BIST_FIRST_FAIL_EN.
//
// state  | meaning
// IDLE   | waiting for start; results of the last run held
// SETTLE | a/b driven, counting down SETTLE_CYC+1 cycles before sampling
// SAMPLE | compare gate outputs with the truth table, step to next vector
// DONE   | one-cycle completion pulse, pass flag updated
module gate_bist_checker
   import gate_bist_checker_pkg::*;
#(
   parameter int SETTLE_CYC = 2,
   parameter int ERR_W      = 4,
   parameter int PASSES     = 1
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              a_o,
   output logic              b_o,
   input  logic [GATE_N-1:0] gate_i,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_cnt,
   output logic [GATE_N-1:0] fail_vec
`ifdef GATE_BIST_FIRST_FAIL_EN
   ,
   output logic [1:0]        first_fail_ab,
   output logic [GATE_N-1:0] first_fail_mism
`endif
);

   localparam logic [3:0]       SETTLE_L  = 4'(SETTLE_CYC);
   localparam logic [7:0]       PASSES_M1 = 8'(PASSES - 1);
   localparam logic [ERR_W-1:0] ERR_MAX   = '1;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [1:0]         r_ab;
   logic [1:0]         w_ab_nxt;
   logic [3:0]         r_cnt;
   logic [3:0]         w_cnt_nxt;
   logic [7:0]         r_pass_cnt;
   logic [7:0]         w_pass_cnt_nxt;
   logic [ERR_W-1:0]   r_err;
   logic [ERR_W-1:0]   w_err_nxt;
   logic [ERR_W-1:0]   w_err_upd;
   logic [GATE_N-1:0]  r_fail;
   logic [GATE_N-1:0]  w_fail_nxt;
   logic               r_pass;
   logic               w_pass_nxt;
   logic               r_busy;
   logic               w_busy_nxt;
   logic               r_done;
   logic               w_done_nxt;
   logic [GATE_N-1:0]  w_expected;
   logic [GATE_N-1:0]  w_mism;
`ifdef GATE_BIST_FIRST_FAIL_EN
   logic [1:0]         r_ff_ab;
   logic [1:0]         w_ff_ab_nxt;
   logic [GATE_N-1:0]  r_ff_mism;
   logic [GATE_N-1:0]  w_ff_mism_nxt;
`endif

   gate_expect u_expect (
      .i_ab       (r_ab),
      .o_expected (w_expected)
   );

   assign w_mism = gate_i ^ w_expected;

   // Error count after this SAMPLE, saturating at the counter's maximum.
   always_comb begin
      w_err_upd = r_err;
      if (|w_mism && r_err != ERR_MAX) begin
         w_err_upd = r_err + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_ab       <= '0;
         r_cnt      <= '0;
         r_pass_cnt <= '0;
         r_err      <= '0;
         r_fail     <= '0;
         r_pass     <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
`ifdef GATE_BIST_FIRST_FAIL_EN
         r_ff_ab    <= '0;
         r_ff_mism  <= '0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_ab       <= w_ab_nxt;
         r_cnt      <= w_cnt_nxt;
         r_pass_cnt <= w_pass_cnt_nxt;
         r_err      <= w_err_nxt;
         r_fail     <= w_fail_nxt;
         r_pass     <= w_pass_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
`ifdef GATE_BIST_FIRST_FAIL_EN
         r_ff_ab    <= w_ff_ab_nxt;
         r_ff_mism  <= w_ff_mism_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_ab_nxt       = r_ab;
      w_cnt_nxt      = r_cnt;
      w_pass_cnt_nxt = r_pass_cnt;
      w_err_nxt      = r_err;
      w_fail_nxt     = r_fail;
      w_pass_nxt     = r_pass;
      w_busy_nxt     = r_busy;
      w_done_nxt     = 1'b0;
`ifdef GATE_BIST_FIRST_FAIL_EN
      w_ff_ab_nxt    = r_ff_ab;
      w_ff_mism_nxt  = r_ff_mism;
`endif
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_ab_nxt       = 2'b00;
               w_cnt_nxt      = SETTLE_L;
               w_pass_cnt_nxt = '0;
               w_err_nxt      = '0;
               w_fail_nxt     = '0;
               w_pass_nxt     = 1'b0;
               w_busy_nxt     = 1'b1;
               w_state_nxt    = ST_SETTLE;
`ifdef GATE_BIST_FIRST_FAIL_EN
               w_ff_ab_nxt    = '0;
               w_ff_mism_nxt  = '0;
`endif
            end
         end
         ST_SETTLE: begin
            if (r_cnt != 4'd0) begin
               w_cnt_nxt = r_cnt - 4'd1;
            end else begin
               w_state_nxt = ST_SAMPLE;
            end
         end
         ST_SAMPLE: begin
            w_fail_nxt = r_fail | w_mism;
            w_err_nxt  = w_err_upd;
`ifdef GATE_BIST_FIRST_FAIL_EN
            // Error count still zero means no earlier mismatch in this run.
            if (|w_mism && r_err == '0) begin
               w_ff_ab_nxt   = r_ab;
               w_ff_mism_nxt = w_mism;
            end
`endif
            if (r_ab == 2'b11 && r_pass_cnt == PASSES_M1) begin
               w_state_nxt = ST_DONE;
               w_done_nxt  = 1'b1;
               w_busy_nxt  = 1'b0;
               w_pass_nxt  = (w_err_upd == '0);
            end else begin
               w_ab_nxt    = r_ab + 2'd1;
               w_cnt_nxt   = SETTLE_L;
               w_state_nxt = ST_SETTLE;
               if (r_ab == 2'b11) begin
                  w_pass_cnt_nxt = r_pass_cnt + 8'd1;
               end
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign a_o      = r_ab[1];
   assign b_o      = r_ab[0];
   assign busy     = r_busy;
   assign done     = r_done;
   assign pass     = r_pass;
   assign err_cnt  = r_err;
   assign fail_vec = r_fail;
`ifdef GATE_BIST_FIRST_FAIL_EN
   assign first_fail_ab   = r_ff_ab;
   assign first_fail_mism = r_ff_mism;
`endif

endmodule

// File: tb/tb_gate_bist_checker.sv
// Bench for gate_bist_checker: two instances (default config; PASSES=2/ERR_W=2)
// each driving a modelled gate block with injectable stuck-at faults.
module tb_gate_bist_checker;

   localparam int S  = 2;
   localparam int P0 = 1;
   localparam int P1 = 2;

   typedef struct {
      int         d;
      logic [6:0] and_m;
      logic [6:0] or_m;
      int         repulse;
      int         exp_err;
      logic [6:0] exp_fail;
      logic       exp_pass;
      logic [1:0] exp_ffab;
      logic [6:0] exp_ffm;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic       start    [2];
   logic       a_o      [2];
   logic       b_o      [2];
   logic       busy     [2];
   logic       done     [2];
   logic       pass     [2];
   logic [6:0] gate_i   [2];
   logic [6:0] fail_vec [2];
   logic [6:0] am       [2];
   logic [6:0] om       [2];
   logic [3:0] err_w    [2];
   logic [1:0] ffab     [2];
   logic [6:0] ffm      [2];
   logic [3:0] err0;
   logic [1:0] err1;

   int checks = 0;
   int errors = 0;

   function automatic logic [6:0] good_of(input logic a, input logic b);
      return {~(a ^ b), a ^ b, ~a, ~(a | b), a | b, ~(a & b), a & b};
   endfunction

   assign gate_i[0] = (good_of(a_o[0], b_o[0]) & am[0]) | om[0];
   assign gate_i[1] = (good_of(a_o[1], b_o[1]) & am[1]) | om[1];
   assign err_w[0]  = err0;
   assign err_w[1]  = {2'b00, err1};

   gate_bist_checker #(.SETTLE_CYC(S), .ERR_W(4), .PASSES(P0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .a_o(a_o[0]), .b_o(b_o[0]),
      .gate_i(gate_i[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
      .err_cnt(err0), .fail_vec(fail_vec[0])
`ifdef GATE_BIST_FIRST_FAIL_EN
      , .first_fail_ab(ffab[0]), .first_fail_mism(ffm[0])
`endif
   );

   gate_bist_checker #(.SETTLE_CYC(S), .ERR_W(2), .PASSES(P1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .a_o(a_o[1]), .b_o(b_o[1]),
      .gate_i(gate_i[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
      .err_cnt(err1), .fail_vec(fail_vec[1])
`ifdef GATE_BIST_FIRST_FAIL_EN
      , .first_fail_ab(ffab[1]), .first_fail_mism(ffm[1])
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input int d, input logic [31:0] got,
                      input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s dut%0d got=%0h want=%0h at %0t", name, d, got, want, $time);
      end
   endtask

   // Behavioural expectation: walk every vector of every pass and accumulate.
   function automatic void model(input int passes, input int errmax,
                                 input logic [6:0] a_m, input logic [6:0] o_m,
                                 output int err, output logic [6:0] fail,
                                 output logic [1:0] ff_ab, output logic [6:0] ff_m);
      bit seen;
      err = 0; fail = '0; ff_ab = '0; ff_m = '0; seen = 0;
      for (int p = 0; p < passes; p++) begin
         for (int v = 0; v < 4; v++) begin
            logic [6:0] g;
            logic [6:0] m;
            g = good_of(v / 2 == 1, v % 2 == 1);
            m = ((g & a_m) | o_m) ^ g;
            fail |= m;
            if (m != 0) begin
               if (!seen) begin
                  ff_ab = 2'(v);
                  ff_m  = m;
                  seen  = 1;
               end
               if (err < errmax) err++;
            end
         end
      end
   endfunction

   task automatic run(input vec_t t);
      int d;
      int n;
      d = t.d;
      n = 4 * ((d == 0) ? P0 : P1) * (S + 2);
      am[d] = t.and_m;
      om[d] = t.or_m;
      @(negedge clk);
      start[d] = 1'b1;
      @(negedge clk);
      start[d] = 1'b0;
      for (int k = 0; k <= n + 1; k++) begin
         if (k > 0) begin
            @(negedge clk);
            start[d] = (k == t.repulse - 1);
         end
         if (k < n) begin
            chk("ab_seq", d, {a_o[d], b_o[d]}, 32'((k / (S + 2)) % 4));
            chk("busy_done", d, {busy[d], done[d]}, 32'b10);
         end else if (k == n) begin
            chk("done_at_end", d, {busy[d], done[d]}, 32'b01);
            chk("err_cnt", d, err_w[d], 32'(t.exp_err));
            chk("fail_vec", d, fail_vec[d], t.exp_fail);
            chk("pass", d, pass[d], t.exp_pass);
`ifdef GATE_BIST_FIRST_FAIL_EN
            chk("first_fail_ab", d, ffab[d], t.exp_ffab);
            chk("first_fail_mism", d, ffm[d], t.exp_ffm);
`endif
         end else begin
            chk("idle_after", d, {busy[d], done[d], a_o[d], b_o[d], pass[d]},
                {27'b0, 4'b0011, t.exp_pass});
         end
      end
      start[d] = 1'b0;
   endtask

   task automatic chk_reset(input int d);
      chk("rst_outputs", d, {a_o[d], b_o[d], busy[d], done[d], pass[d]}, 32'b0);
      chk("rst_err", d, err_w[d], 32'b0);
      chk("rst_fail", d, fail_vec[d], 32'b0);
`ifdef GATE_BIST_FIRST_FAIL_EN
      chk("rst_ff", d, {ffab[d], ffm[d]}, 32'b0);
`endif
   endtask

   vec_t tbl [5];

   initial begin
      vec_t r;
      int   e;
      logic [6:0] f;
      logic [1:0] fa;
      logic [6:0] fm;

      tbl[0] = '{0, 7'h7F, 7'h00, -1, 0, 7'b0000000, 1'b1, 2'b00, 7'b0000000};
      tbl[1] = '{0, 7'b1111101, 7'h00, -1, 3, 7'b0000010, 1'b0, 2'b00, 7'b0000010};
      tbl[2] = '{1, 7'h00, 7'h00, -1, 3, 7'b1111111, 1'b0, 2'b00, 7'b1011010};
      tbl[3] = '{1, 7'h7F, 7'h00, 5, 0, 7'b0000000, 1'b1, 2'b00, 7'b0000000};
      tbl[4] = '{0, 7'h7F, 7'b0100000, -1, 2, 7'b0100000, 1'b0, 2'b00, 7'b0100000};

      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         start[i] = 1'b0;
         am[i] = 7'h7F;
         om[i] = 7'h00;
      end
      repeat (3) @(negedge clk);
      chk_reset(0);
      chk_reset(1);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) run(tbl[i]);

      // Abort during the second SETTLE of a faulty run, then rerun clean.
      am[0] = 7'h7F;
      om[0] = 7'b0100000;
      @(negedge clk);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (6) @(negedge clk);
      chk("abort_pre", 0, {a_o[0], b_o[0], busy[0], err_w[0]}, {25'b0, 3'b011, 4'd1});
      #2 rst_n = 1'b0;
      #1 chk_reset(0);
      @(negedge clk);
      chk_reset(0);
      rst_n = 1'b1;
      run(tbl[0]);

      for (int i = 0; i < 8; i++) begin
         r.d       = int'($urandom_range(0, 1));
         r.and_m   = ~(7'($urandom) & 7'($urandom));
         r.or_m    = 7'($urandom) & 7'($urandom) & 7'($urandom);
         r.repulse = int'($urandom_range(2, 12));
         model((r.d == 0) ? P0 : P1, (r.d == 0) ? 15 : 3, r.and_m, r.or_m, e, f, fa, fm);
         r.exp_err  = e;
         r.exp_fail = f;
         r.exp_pass = (e == 0);
         r.exp_ffab = fa;
         r.exp_ffm  = fm;
         run(r);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
